activate_diff_sequencer: RTL and testbench
==========================================

ACTIVATE_DIFF_SEQUENCER -- requirements
Module: activate_diff_sequencer

Interface
REQ-001 Parameter drain_cycles, default 4, meaning idle cycles after the last token before done, range 0..255.
REQ-002 Parameter layer_count_size, default 8, meaning the width of num_layers and cfg_layer_addr.
REQ-003 Parameter row_count_size, default 16, meaning the width of cfg_row_count.
REQ-004 Port clk  input  1  is the single clock; all state changes on its rising edge.
REQ-005 Port rst_n  input  1  is the synchronous active-low reset.
REQ-006 Port start  input  1  requests one training pass; it is sampled only in IDLE.
REQ-007 Port abort  input  1  terminates the pass.
REQ-008 Port num_layers  input  layer_count_size  gives the layer count L; it is latched when start is accepted.
REQ-009 Port cfg_layer_addr  output  layer_count_size  carries the current layer counter to the row-count lookup, combinationally.
REQ-010 Port cfg_row_count  input  row_count_size  returns the row count of layer cfg_layer_addr in the same cycle.
REQ-011 Port issue_valid  output  1  marks a token as present.
REQ-012 Port issue_ready  input  1  indicates the downstream pipeline accepts the token.
REQ-013 Port w_layer_index  output  32  carries the token layer, zero-extended.
REQ-014 Port w_row_index  output  32  carries the token row, zero-extended.
REQ-015 Port is_update  output  1  is high for backward-pass tokens.
REQ-016 Port backprop_cost  output  1  is high for the cost token.
REQ-017 Port busy  output  1  is high in every state except IDLE.
REQ-018 Port done  output  1  is a one-cycle completion pulse.

Function
REQ-019 The FSM SHALL use the states IDLE, FWD, COST, BWD, DRAIN and DONE.
REQ-020 A transfer SHALL occur when issue_valid and issue_ready are both high; while issue_valid is high and issue_ready is low, all token outputs SHALL hold stable.
REQ-021 IDLE with start high and abort low SHALL load layer=0 and row=0 and go to FWD; if L=0, it SHALL go to DONE instead.
REQ-022 In FWD, issue_valid SHALL equal (cfg_row_count != 0), and the token SHALL be (layer, row, is_update=0, backprop_cost=0).
REQ-023 In FWD, a transfer with row = cfg_row_count-1, or any cycle with cfg_row_count = 0, SHALL set row=0 and layer+1.
REQ-024 In FWD, when that layer is L-1, the FSM SHALL go to COST instead of advancing the layer.
REQ-025 Consecutive nonzero-row layers SHALL issue without a bubble; each zero-row layer SHALL cost exactly one cycle with issue_valid=0.
REQ-026 COST SHALL present one token (layer=L-1, row=0, is_update=0, backprop_cost=1); on transfer it SHALL load layer=L-1 and row=0 and go to BWD.
REQ-027 BWD SHALL apply the FWD rules with is_update=1 and the layer decrementing from L-1 to 0.
REQ-028 In BWD, completion of layer 0 SHALL go to DRAIN, or to DONE if drain_cycles=0.
REQ-029 DRAIN SHALL keep issue_valid=0 for exactly drain_cycles cycles and then go to DONE.
REQ-030 DONE SHALL assert done=1 for one cycle and then go to IDLE.
REQ-031 Abort high in any non-IDLE state SHALL force IDLE on the next edge with no done pulse; a handshake in that same cycle still counts for downstream.
REQ-032 In IDLE, abort SHALL have priority over start, and the FSM SHALL stay in IDLE.
REQ-033 start SHALL be ignored outside IDLE, and num_layers changes after acceptance SHALL have no effect.
REQ-034 The row and layer counters SHALL never exceed cfg_row_count-1 and L-1, and SHALL never wrap.
REQ-035 The only combinational input-to-output paths SHALL be cfg_row_count to issue_valid and layer to cfg_layer_addr.

Reset
REQ-036 rst_n low at a clock edge SHALL force IDLE and clear layer, row and the drain counter, overriding start and abort.
REQ-037 After reset, issue_valid, is_update, backprop_cost, busy and done SHALL be 0, and w_layer_index, w_row_index and cfg_layer_addr SHALL be 0.
REQ-038 Reset mid-pass SHALL behave identically to reset from IDLE.

Verification
REQ-039 L=2, rows {3,2}, drain_cycles=4, issue_ready=1, start in cycle 0 -> the bench SHALL see:
- issue_valid high in cycles 1-11;
- tokens (0,0..2), (1,0..1), cost (1,0), then (1,0..1) and (0,0..2) with is_update=1;
- done in cycle 16;
- busy in cycles 1-16.
REQ-040 The same pass with issue_ready low in cycles 2-4 -> the token (0,1) SHALL be held in cycles 2-5, and done SHALL move to cycle 19.
REQ-041 L=3, rows {2,0,1}, drain_cycles=0 -> the bench SHALL see:
- a one-cycle issue_valid=0 bubble at layer 1 in each pass;
- 7 transfers in total;
- done directly after the last BWD transfer.
REQ-042 L=0 with start -> busy SHALL be high in cycle 1 with done=1 in that cycle, and there SHALL be no tokens.
REQ-043 abort in cycle 6 of the REQ-039 pass -> IDLE in cycle 7, no done, and a new start in cycle 8 SHALL restart from (0,0).
REQ-044 rst_n low in cycle 9 of a pass, with start held high -> all outputs SHALL be 0 in cycle 10, and the FSM SHALL stay in IDLE until rst_n is high.

Source files
------------

// File: rtl/activate_diff_sequencer.sv
// Training-pass token sequencer: forward rows per layer, one cost token,
// backward rows per layer in reverse order, optional drain, then a done pulse.
module activate_diff_sequencer #(
  parameter int unsigned drain_cycles     = 4,
  parameter int unsigned layer_count_size = 8,
  parameter int unsigned row_count_size   = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic [layer_count_size-1:0] num_layers,
  output logic [layer_count_size-1:0] cfg_layer_addr,
  input  logic [row_count_size-1:0]   cfg_row_count,
  output logic                        issue_valid,
  input  logic                        issue_ready,
  output logic [31:0]                 w_layer_index,
  output logic [31:0]                 w_row_index,
  output logic                        is_update,
  output logic                        backprop_cost,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned LAYER_W = layer_count_size;
  localparam int unsigned ROW_W   = row_count_size;
  localparam int unsigned DRAIN_W = 8;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST =
    (drain_cycles == 0) ? '0 : DRAIN_W'(drain_cycles - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FWD,
    S_COST,
    S_BWD,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [LAYER_W-1:0] layer_q, layer_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic [LAYER_W-1:0] nl_q, nl_d;

  logic               xfer;
  logic               row_last;
  logic               layer_done;
  logic [LAYER_W-1:0] last_layer;

  // Token presence: row-walking states follow the looked-up row count.
  always_comb begin
    issue_valid = 1'b0;
    if ((state_q == S_FWD) || (state_q == S_BWD)) begin
      issue_valid = (cfg_row_count != '0);
    end else if (state_q == S_COST) begin
      issue_valid = 1'b1;
    end
  end

  assign xfer       = issue_valid && issue_ready;
  assign row_last   = (row_q == (cfg_row_count - ROW_W'(1)));
  assign layer_done = (cfg_row_count == '0) || (xfer && row_last);
  assign last_layer = nl_q - LAYER_W'(1);

  // Register-sourced token and status outputs.
  assign cfg_layer_addr = layer_q;
  assign w_layer_index  = 32'(layer_q);
  assign w_row_index    = 32'(row_q);
  assign is_update      = (state_q == S_BWD);
  assign backprop_cost  = (state_q == S_COST);
  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);

  // Next-state and counter update.
  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    row_d   = row_q;
    drain_d = drain_q;
    nl_d    = nl_q;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          nl_d    = num_layers;
          layer_d = '0;
          row_d   = '0;
          state_d = (num_layers == '0) ? S_DONE : S_FWD;
        end
      end

      S_FWD: begin
        if (layer_done) begin
          row_d = '0;
          if (layer_q == last_layer) begin
            state_d = S_COST;
          end else begin
            layer_d = layer_q + LAYER_W'(1);
          end
        end else if (xfer) begin
          row_d = row_q + ROW_W'(1);
        end
      end

      S_COST: begin
        if (issue_ready) begin
          layer_d = last_layer;
          row_d   = '0;
          state_d = S_BWD;
        end
      end

      S_BWD: begin
        if (layer_done) begin
          row_d = '0;
          if (layer_q == '0) begin
            drain_d = '0;
            state_d = (drain_cycles == 0) ? S_DONE : S_DRAIN;
          end else begin
            layer_d = layer_q - LAYER_W'(1);
          end
        end else if (xfer) begin
          row_d = row_q + ROW_W'(1);
        end
      end

      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q + DRAIN_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort ends any pass immediately, without a done pulse.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      layer_d = '0;
      row_d   = '0;
      drain_d = '0;
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      layer_q <= '0;
      row_q   <= '0;
      drain_q <= '0;
      nl_q    <= '0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      row_q   <= row_d;
      drain_q <= drain_d;
      nl_q    <= nl_d;
    end
  end

endmodule

// File: tb/tb_activate_diff_sequencer.sv
// Scoreboard bench: a pass-level model pushes expected tokens and done
// timing; a negedge monitor pops and compares whatever the DUT presents.
`timescale 1ns/1ps
module tb_activate_diff_sequencer;

  localparam int unsigned LW      = 8;
  localparam int unsigned RW      = 16;
  localparam int unsigned DRAIN_A = 4;
  localparam int unsigned DRAIN_B = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic          abort = 1'b0;
  logic          issue_ready = 1'b0;
  logic [LW-1:0] num_layers = '0;
  logic          start_a = 1'b0, start_b = 1'b0;

  logic [LW-1:0] addr_a, addr_b;
  logic [RW-1:0] rc_a, rc_b;
  logic          valid_a, valid_b, upd_a, upd_b, cost_a, cost_b;
  logic          busy_a, busy_b, done_a, done_b;
  logic [31:0]   lay_a, lay_b, row_a, row_b;

  logic [RW-1:0] rows_mem [0:255];
  assign rc_a = rows_mem[addr_a];
  assign rc_b = rows_mem[addr_b];

  activate_diff_sequencer #(.drain_cycles(DRAIN_A), .layer_count_size(LW), .row_count_size(RW)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort), .num_layers(num_layers),
    .cfg_layer_addr(addr_a), .cfg_row_count(rc_a), .issue_valid(valid_a), .issue_ready(issue_ready),
    .w_layer_index(lay_a), .w_row_index(row_a), .is_update(upd_a), .backprop_cost(cost_a),
    .busy(busy_a), .done(done_a));

  activate_diff_sequencer #(.drain_cycles(DRAIN_B), .layer_count_size(LW), .row_count_size(RW)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort), .num_layers(num_layers),
    .cfg_layer_addr(addr_b), .cfg_row_count(rc_b), .issue_valid(valid_b), .issue_ready(issue_ready),
    .w_layer_index(lay_b), .w_row_index(row_b), .is_update(upd_b), .backprop_cost(cost_b),
    .busy(busy_b), .done(done_b));

  // Monitor view of whichever instance is currently exercised.
  bit          sel = 1'b0;
  logic        m_valid, m_upd, m_cost, m_busy, m_done;
  logic [31:0] m_layer, m_row;
  assign m_valid = sel ? valid_b : valid_a;
  assign m_upd   = sel ? upd_b   : upd_a;
  assign m_cost  = sel ? cost_b  : cost_a;
  assign m_busy  = sel ? busy_b  : busy_a;
  assign m_done  = sel ? done_b  : done_a;
  assign m_layer = sel ? lay_b   : lay_a;
  assign m_row   = sel ? row_b   : row_a;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got event, expected none (cycle %0d)", name, cyc);
  endtask

  typedef struct {
    bit is_done;
    int layer;
    int row;
    bit upd;
    bit cost;
    int cyc;
  } exp_t;

  exp_t exp_q[$];

  // Pass model: token list from the row table; done cycle from cycle budget.
  task automatic push_pass(input int L, input int drain, input int limit,
                           input bit with_done, input int s);
    exp_t toks[$];
    exp_t e;
    int   sum;
    sum = 0;
    for (int l = 0; l < L; l++) begin
      for (int r = 0; r < int'(rows_mem[l]); r++) begin
        e = '{1'b0, l, r, 1'b0, 1'b0, 0};
        toks.push_back(e);
      end
      sum += (rows_mem[l] == '0) ? 1 : int'(rows_mem[l]);
    end
    if (L > 0) begin
      e = '{1'b0, L - 1, 0, 1'b0, 1'b1, 0};
      toks.push_back(e);
      for (int l = L - 1; l >= 0; l--) begin
        for (int r = 0; r < int'(rows_mem[l]); r++) begin
          e = '{1'b0, l, r, 1'b1, 1'b0, 0};
          toks.push_back(e);
        end
      end
    end
    for (int i = 0; i < toks.size(); i++) begin
      if (limit < 0 || i < limit) exp_q.push_back(toks[i]);
    end
    if (with_done) begin
      e = '{1'b1, 0, 0, 1'b0, 1'b0, s + ((L == 0) ? 1 : 2 * sum + 2 + drain)};
      exp_q.push_back(e);
    end
  endtask

  // Monitor: hold stability, token order, done timing (shifted by stalls).
  int          stall_cnt = 0;
  int          xfer_cnt  = 0;
  bit          hold_pend = 1'b0;
  logic [31:0] hold_layer, hold_row;
  logic [1:0]  hold_flags;
  always @(negedge clk) begin
    exp_t e;
    if (!m_busy) stall_cnt = 0;
    if (hold_pend) begin
      chk("hold_valid", m_valid, 1);
      chk("hold_layer", m_layer, hold_layer);
      chk("hold_row", m_row, hold_row);
      chk("hold_flags", {m_upd, m_cost}, hold_flags);
    end
    hold_pend  = rst_n && !abort && m_valid && !issue_ready;
    hold_layer = m_layer;
    hold_row   = m_row;
    hold_flags = {m_upd, m_cost};
    if (m_valid && issue_ready) begin
      xfer_cnt++;
      if (exp_q.size() == 0 || exp_q[0].is_done) begin
        fail_now("unexpected_token");
      end else begin
        e = exp_q.pop_front();
        chk("tok_layer", m_layer, e.layer);
        chk("tok_row", m_row, e.row);
        chk("tok_flags", {m_upd, m_cost}, {e.upd, e.cost});
      end
    end
    if (m_done) begin
      if (exp_q.size() == 0 || !exp_q[0].is_done) begin
        fail_now("unexpected_done");
      end else begin
        e = exp_q.pop_front();
        chk("done_cycle", cyc, e.cyc + stall_cnt);
      end
    end
    if (m_valid && !issue_ready) stall_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input bit inst, input int L, input int limit, input bit with_done);
    sel        = inst;
    num_layers = LW'(L);
    if (inst) start_b = 1'b1;
    else      start_a = 1'b1;
    push_pass(L, inst ? int'(DRAIN_B) : int'(DRAIN_A), limit, with_done, cyc);
  endtask

  // Runs until the selected instance is idle, with optional input noise.
  task automatic wait_idle(input bit noise);
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 2000 && !idle; i++) begin
      tick();
      if (noise) begin
        issue_ready = ($urandom_range(3, 0) != 0);
        num_layers  = LW'($urandom_range(255, 0));
        start_a     = !sel && m_busy && ($urandom_range(3, 0) == 0);
        start_b     = sel && m_busy && ($urandom_range(3, 0) == 0);
      end else begin
        start_a = 1'b0;
        start_b = 1'b0;
      end
      if (!m_busy) begin
        idle    = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
      end
    end
    if (!idle) fail_now("pass_timeout");
  endtask

  initial begin
    int vpat [0:9];
    int s;
    int x0;
    bit r_inst;
    int r_l;
    vpat = '{1, 1, 0, 1, 1, 1, 0, 1, 1, 0};
    for (int i = 0; i < 256; i++) rows_mem[i] = '0;

    // Reset overrides a held start.
    start_a = 1'b1;
    start_b = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_valid", {valid_a, valid_b}, 0);
    chk("rst_busy", {busy_a, busy_b}, 0);
    chk("rst_done", {done_a, done_b}, 0);
    chk("rst_flags", {upd_a, cost_a, upd_b, cost_b}, 0);
    chk("rst_index", lay_a | row_a | lay_b | row_b, 0);
    chk("rst_addr", {addr_a, addr_b}, 0);
    tick();
    rst_n   = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    tick();

    // L=2, rows {3,2}, always ready.
    rows_mem[0] = RW'(3);
    rows_mem[1] = RW'(2);
    issue_ready = 1'b1;
    do_start(1'b0, 2, -1, 1'b1);
    for (int c = 1; c <= 17; c++) begin
      tick();
      start_a = 1'b0;
      @(negedge clk);
      chk("t1_valid", m_valid, (c <= 11));
      chk("t1_busy", m_busy, (c <= 16));
      chk("t1_done", m_done, (c == 16));
    end
    tick();

    // Same pass with ready low in cycles 2-4.
    do_start(1'b0, 2, -1, 1'b1);
    for (int c = 1; c <= 20; c++) begin
      tick();
      start_a     = 1'b0;
      issue_ready = !(c >= 2 && c <= 4);
      @(negedge clk);
      if (c >= 2 && c <= 5) begin
        chk("t2_hold_layer", m_layer, 0);
        chk("t2_hold_row", m_row, 1);
      end
      chk("t2_done", m_done, (c == 19));
    end
    tick();
    issue_ready = 1'b1;

    // L=3, rows {2,0,1}, no drain.
    rows_mem[0] = RW'(2);
    rows_mem[1] = RW'(0);
    rows_mem[2] = RW'(1);
    x0 = xfer_cnt;
    do_start(1'b1, 3, -1, 1'b1);
    for (int c = 1; c <= 11; c++) begin
      tick();
      start_b = 1'b0;
      @(negedge clk);
      chk("t3_valid", m_valid, (c <= 10) ? vpat[c-1] : 0);
      chk("t3_done", m_done, (c == 10));
    end
    tick();
    chk("t3_xfers", xfer_cnt - x0, 7);

    // L=0: immediate done.
    do_start(1'b0, 0, -1, 1'b1);
    for (int c = 1; c <= 3; c++) begin
      tick();
      start_a = 1'b0;
      @(negedge clk);
      chk("t4_busy", m_busy, (c == 1));
      chk("t4_done", m_done, (c == 1));
      chk("t4_valid", m_valid, 0);
    end
    tick();

    // Abort in cycle 6, restart in cycle 8.
    rows_mem[0] = RW'(3);
    rows_mem[1] = RW'(2);
    do_start(1'b0, 2, 6, 1'b0);
    for (int c = 1; c <= 9; c++) begin
      tick();
      start_a = 1'b0;
      abort   = (c == 6);
      if (c == 8) do_start(1'b0, 2, -1, 1'b1);
      @(negedge clk);
      if (c == 7 || c == 8) begin
        chk("t5_idle_busy", m_busy, 0);
        chk("t5_idle_done", m_done, 0);
      end
      if (c == 9) begin
        chk("t5_restart_layer", m_layer, 0);
        chk("t5_restart_row", m_row, 0);
        chk("t5_restart_valid", m_valid, 1);
      end
    end
    wait_idle(1'b0);

    // Reset in cycle 9 with start held high.
    tick();
    do_start(1'b0, 2, 9, 1'b0);
    for (int c = 1; c <= 13; c++) begin
      tick();
      if (c == 9) rst_n = 1'b0;
      if (c == 12) begin
        rst_n   = 1'b1;
        start_a = 1'b0;
      end
      @(negedge clk);
      if (c == 10) begin
        chk("t6_zero_ctl", {m_valid, m_upd, m_cost, m_done}, 0);
        chk("t6_zero_idx", m_layer | m_row, 0);
        chk("t6_zero_addr", addr_a, 0);
      end
      if (c >= 10) chk("t6_idle_busy", m_busy, 0);
    end
    tick();
    chk("t6_drained", exp_q.size(), 0);

    // Randomised passes with backpressure and ignored start/num_layers noise.
    for (int p = 0; p < 40; p++) begin
      r_inst = 1'($urandom_range(1, 0));
      r_l    = $urandom_range(5, 0);
      for (int l = 0; l < 6; l++) rows_mem[l] = RW'($urandom_range(4, 0));
      tick();
      issue_ready = ($urandom_range(3, 0) != 0);
      do_start(r_inst, r_l, -1, 1'b1);
      wait_idle(1'b1);
      chk("rand_drained", exp_q.size(), 0);
      exp_q.delete();
    end

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
